// File: rtl/conv_encoder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : conv_encoder_pkg                                            |
// | Purpose  : Shared code parameters and FSM state encoding for the       |
// |            rate-1/2 convolutional encoder. The same K/G0/G1 defaults   |
// |            are used by the decoder BMU and the loopback bench.         |
// | Contents : CONV_K, CONV_G0, CONV_G1, enc_state_t                       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package conv_encoder_pkg;

  // Constraint length 7 gives 64 trellis states.
  localparam int         CONV_K  = 7;
  // Generator MSBs tap the current input bit.
  localparam logic [6:0] CONV_G0 = 7'o171;
  localparam logic [6:0] CONV_G1 = 7'o133;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TAIL = 1'b1
  } enc_state_t;

endpackage : conv_encoder_pkg
`default_nettype wire

// File: rtl/conv_encoder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : conv_encoder_if                                             |
// | Purpose  : Bit-in / symbol-out handshake bundle of the encoder.        |
// | Ports    : in_valid/in_ready/in_bit/in_last   bit stream side          |
// |            out_valid/out_ready/out_sym/out_last symbol stream side     |
// |            busy                                 encoder activity flag  |
// |            master: bit source + symbol consumer; slave: the encoder    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface conv_encoder_if;

  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;
  logic       busy;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last, busy
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last, busy
  );

endinterface : conv_encoder_if
`default_nettype wire

// File: rtl/conv_encoder_sym_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : conv_sym_gen                                                |
// | Purpose  : Combinational parity generator: register word {b, sr} ->    |
// |            2-bit code symbol {G1 parity, G0 parity}.                   |
// | Ports    : w   in  K  register word, w[K-1] is the current input bit   |
// |            sym out 2  {^(w & G1), ^(w & G0)}                           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module conv_sym_gen
  import conv_encoder_pkg::*;
#(
  parameter int         K  = CONV_K,
  parameter logic [K-1:0] G0 = CONV_G0,
  parameter logic [K-1:0] G1 = CONV_G1
) (
  input  wire logic [K-1:0] w,
  output logic      [1:0]   sym
);

  assign sym = {^(w & G1), ^(w & G0)};

endmodule : conv_sym_gen
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : conv_encoder                                                |
// | Purpose  : Rate-1/2 feedforward convolutional encoder with optional    |
// |            K-1 zero tail per frame, valid/ready on both sides.         |
// | Ports    : clk  in  clock, rising edge                                 |
// |            rst  in  asynchronous active-high reset                     |
// |            bus  slave side of conv_encoder_if (bit in, symbol out,     |
// |                 busy)                                                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module conv_encoder
  import conv_encoder_pkg::*;
#(
  parameter int           K       = CONV_K,
  parameter logic [K-1:0] G0      = CONV_G0,
  parameter logic [K-1:0] G1      = CONV_G1,
  parameter bit           TAIL_EN = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  conv_encoder_if.slave     bus
);

  localparam int             TCW       = $clog2(K);
  localparam logic [TCW-1:0] TAIL_INIT = TCW'(K - 2);

  enc_state_t     state;
  logic [K-2:0]   sr;        // sr[K-2] is the most recent past bit
  logic [TCW-1:0] tail_cnt;

  logic           load_ok;
  logic           accept;
  logic           tail_load;
  logic           b;
  logic [K-2:0]   sr_next;
  logic [1:0]     sym;

  // The single output register may be refilled when empty or being drained.
  assign load_ok   = !bus.out_valid || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;
  assign tail_load = (state == ST_TAIL) && load_ok;
  assign b         = (state == ST_RUN) ? bus.in_bit : 1'b0;
  assign sr_next   = {b, sr[K-2:1]};

  assign bus.in_ready = (state == ST_RUN) && load_ok;
  assign bus.busy     = (state == ST_TAIL) || bus.out_valid;

  conv_sym_gen #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_sym_gen (
    .w   ({b, sr}),
    .sym (sym)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      sr            <= '0;
      tail_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sym   <= 2'b00;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_sym   <= sym;
      bus.out_last  <= bus.in_last && !TAIL_EN;
      sr            <= sr_next;
      if (bus.in_last) begin
        if (TAIL_EN) begin
          state    <= ST_TAIL;
          tail_cnt <= TAIL_INIT;
        end else begin
          // Without a tail the next frame must still start from state 0.
          sr <= '0;
        end
      end
    end else if (tail_load) begin
      bus.out_valid <= 1'b1;
      bus.out_sym   <= sym;
      sr            <= sr_next;
      if (tail_cnt == '0) begin
        // K-1 zeros have been shifted in, so sr is all-zero here.
        bus.out_last <= 1'b1;
        state        <= ST_RUN;
      end else begin
        bus.out_last <= 1'b0;
        tail_cnt     <= tail_cnt - 1'b1;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end
  end

endmodule : conv_encoder
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_conv_encoder                                             |
// | Purpose  : Self-checking bench for conv_encoder (tail and no-tail      |
// |            builds) against a convolution-sum reference model.         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_conv_encoder;
  import conv_encoder_pkg::*;

  localparam int           K  = CONV_K;
  localparam logic [K-1:0] G0 = CONV_G0;
  localparam logic [K-1:0] G1 = CONV_G1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_encoder_if bus ();
  conv_encoder_if bus0 ();

  conv_encoder #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  conv_encoder #(.K(K), .G0(G0), .G1(G1), .TAIL_EN(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Symbol n of a frame is the convolution of the frame's bit sequence
  // (data followed by K-1 zeros) with each generator polynomial.
  bit         hist[$];
  logic [2:0] exp_q[$];   // {last, sym}
  logic [2:0] cap_q[$];   // observed {last, sym}
  int         last_seen   = 0;
  int         frames_done = 0;
  bit         abort       = 1'b0;

  function automatic logic [1:0] conv_sym(input int n);
    logic p0 = 1'b0;
    logic p1 = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (n - i >= 0 && hist[n - i]) begin
        p0 ^= G0[K-1-i];
        p1 ^= G1[K-1-i];
      end
    end
    return {p1, p0};
  endfunction

  task automatic model_bit(input bit b, input bit last);
    hist.push_back(b);
    exp_q.push_back({1'b0, conv_sym(hist.size() - 1)});
    if (last) begin
      for (int t = 0; t < K - 1; t++) begin
        logic lf;
        lf = (t == K - 2);
        hist.push_back(1'b0);
        exp_q.push_back({lf, conv_sym(hist.size() - 1)});
      end
      hist.delete();
      frames_done++;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [2:0] obs;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        obs = {bus.out_last, bus.out_sym};
        if (exp_q.size() == 0) check("unexpected_sym", 32'(obs), 32'h100);
        else                   check("sym", 32'(obs), 32'(exp_q.pop_front()));
        cap_q.push_back(obs);
        if (bus.out_last) last_seen++;
      end
      if (bus.in_valid && bus.in_ready) model_bit(bus.in_bit, bus.in_last);
    end
  end

  // ---------------- consumer ready ----------------
  bit rdy_mode  = 1'b0;   // 1: random out_ready
  bit rdy_force = 1'b1;
  always begin
    @(posedge clk);
    #1;
    bus.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // ---------------- source ----------------
  task automatic send_bit(input bit b, input bit last, input bit gaps);
    bit acc = 1'b0;
    int n   = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = last;
    while (!acc && !abort) begin
      @(negedge clk);
      acc = bus.in_ready && !rst;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        check("in_accept_timeout", 32'd0, 32'd1);
        abort = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  // mode 0: random bits, 1: all zero, 2: impulse
  task automatic send_frame(input int len, input int mode, input bit gaps);
    bit b;
    for (int i = 0; i < len && !abort; i++) begin
      b = (mode == 0) ? 1'($urandom) : (mode == 2) ? (i == 0) : 1'b0;
      send_bit(b, i == len - 1, gaps);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size() == 0 && !bus.busy), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] imp_exp [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
  logic [2:0] t0_exp  [3] = '{3'b011, 3'b001, 3'b100};
  bit         t0_bits [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    logic [2:0] held;
    logic [1:0] acc_or;
    int         nlast;
    int         lastpos;

    bus.in_valid  = 1'b0; bus.in_bit  = 1'b0; bus.in_last  = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_bit = 1'b0; bus0.in_last = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({bus.out_valid, bus.out_last, bus.busy, bus.out_sym}), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Random back-to-back frames with gaps on both sides.
    rdy_mode = 1'b1;
    send_frame(1, 0, 1'b1);
    send_frame(8, 0, 1'b1);
    send_frame(100, 0, 1'b1);
    drain();
    check("random_frame_lasts", 32'(last_seen), 32'(frames_done));

    // Impulse response.
    rdy_mode = 1'b0; rdy_force = 1'b1;
    @(posedge clk); #1;
    cap_q.delete();
    send_frame(1, 2, 1'b0);
    drain();
    check("impulse_count", 32'(cap_q.size()), 32'd7);
    for (int k = 0; k < 7 && k < cap_q.size(); k++)
      check($sformatf("impulse_%0d", k), 32'(cap_q[k]), 32'({k == 6, imp_exp[k]}));

    // All-zero 16-bit frame.
    cap_q.delete();
    send_frame(16, 1, 1'b0);
    drain();
    check("zero_count", 32'(cap_q.size()), 32'd22);
    acc_or = 2'b00; nlast = 0; lastpos = -1;
    for (int k = 0; k < cap_q.size(); k++) begin
      acc_or |= cap_q[k][1:0];
      if (cap_q[k][2]) begin nlast++; lastpos = k; end
    end
    check("zero_syms", 32'(acc_or), 32'd0);
    check("zero_last_count", 32'(nlast), 32'd1);
    check("zero_last_pos", 32'(lastpos), 32'd21);
    @(negedge clk);
    check("zero_sr", 32'(dut.sr), 32'd0);
    check("zero_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Backpressure mid-frame.
    fork
      send_frame(20, 0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        rdy_force = 1'b0;
        @(posedge clk); #2;
        held = {bus.out_valid, bus.out_last, bus.out_sym[1]} ;
        held = {bus.out_valid, bus.out_sym};
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", 32'(bus.in_ready), 32'd0);
          check("bp_hold", 32'({bus.out_valid, bus.out_sym}), 32'(held));
        end
        rdy_force = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a frame.
    rdy_mode = 1'b1;
    fork
      send_frame(100, 0, 1'b1);
      begin
        repeat (25) @(negedge clk);
        rst   = 1'b1;
        abort = 1'b1;
        #1;
        check("rst_outputs", 32'({bus.out_valid, bus.out_last, bus.busy}), 32'd0);
        exp_q.delete();
        hist.delete();
      end
    join
    rdy_mode = 1'b0; rdy_force = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    abort = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rdy_mode = 1'b1;
    send_frame(8, 0, 1'b1);
    drain();
    rdy_mode = 1'b0;
    check("frame_lasts_total", 32'(last_seen), 32'(frames_done));

    // No-tail build: {1,0,1} then {1}.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_bit   = t0_bits[i];
      bus0.in_last  = (i == 2);
      @(posedge clk); #1;
      check($sformatf("notail_sym%0d", i),
            32'({bus0.out_valid, bus0.out_last, bus0.out_sym}), 32'({1'b1, t0_exp[i]}));
    end
    check("notail_sr_cleared", 32'(dut0.sr), 32'd0);
    bus0.in_bit  = 1'b1;
    bus0.in_last = 1'b1;
    @(posedge clk); #1;
    check("notail_next", 32'({bus0.out_valid, bus0.out_last, bus0.out_sym}), 32'b1111);
    bus0.in_valid = 1'b0;
    @(posedge clk); #1;
    check("notail_idle", 32'(bus0.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_conv_encoder
`default_nettype wire
